// File: rtl/sfm_int_packer.sv
// Gathers R = FP_WIDTH/INT_WIDTH sparse cast beats into one dense DATA_WIDTH word; 1-cycle latency, blocks input only while a full word is stalled.
// Optional statistics (words_o, partial_o) are built when SFM_INT_PACKER_STATS_EN is defined.
module sfm_int_packer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned FP_WIDTH   = 16,
  parameter int unsigned INT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  input  logic                    stream_i_valid,
  output logic                    stream_i_ready,
  input  logic [DATA_WIDTH-1:0]   stream_i_data,
  input  logic [DATA_WIDTH/8-1:0] stream_i_strb,
  output logic                    stream_o_valid,
  input  logic                    stream_o_ready,
  output logic [DATA_WIDTH-1:0]   stream_o_data,
  output logic [DATA_WIDTH/8-1:0] stream_o_strb
`ifdef SFM_INT_PACKER_STATS_EN
  ,
  output logic [31:0]             words_o,
  output logic [31:0]             partial_o
`endif
);

  localparam int unsigned R     = FP_WIDTH / INT_WIDTH;
  localparam int unsigned H     = DATA_WIDTH / R;
  localparam int unsigned HB    = H / 8;
  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(R);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  out_fire, in_fire;

  assign out_fire = enable_i & full_q & stream_o_ready;
  assign in_fire  = enable_i & stream_i_valid & stream_i_ready;
  assign busy_o   = full_q | (cnt_q != '0);

  // Pass-through is purely combinational; the packing registers simply hold.
  assign stream_o_valid = enable_i ? full_q  : stream_i_valid;
  assign stream_o_data  = enable_i ? word_q  : stream_i_data;
  assign stream_o_strb  = enable_i ? wstrb_q : stream_i_strb;
  assign stream_i_ready = enable_i ? (!full_q | stream_o_ready) : stream_o_ready;

`ifdef SFM_INT_PACKER_STATS_EN
  logic flushed_q, flushed_d;
`endif

  always_comb begin
    word_d  = word_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
`ifdef SFM_INT_PACKER_STATS_EN
    flushed_d = flushed_q;
`endif
    if (out_fire) begin
      word_d  = '0;
      wstrb_d = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
`ifdef SFM_INT_PACKER_STATS_EN
      flushed_d = 1'b0;
`endif
    end
    if (in_fire) begin
      word_d[int'(cnt_d) * H +: H]   = stream_i_data[H-1:0];
      wstrb_d[int'(cnt_d) * HB +: HB] = stream_i_strb[HB-1:0];
      if (cnt_d == LAST) begin
        full_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
    // An empty flush must not create a word, so only a partial one is closed.
    if (enable_i && flush_i && (cnt_d != '0) && !full_d) begin
      full_d = 1'b1;
      cnt_d  = '0;
`ifdef SFM_INT_PACKER_STATS_EN
      flushed_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      word_q  <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

`ifdef SFM_INT_PACKER_STATS_EN
  logic [31:0] words_q, partial_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q   <= '0;
      partial_q <= '0;
      flushed_q <= 1'b0;
    end else if (clear_i) begin
      words_q   <= '0;
      partial_q <= '0;
      flushed_q <= 1'b0;
    end else begin
      flushed_q <= flushed_d;
      if (out_fire && (words_q != '1)) words_q <= words_q + 32'd1;
      if (out_fire && flushed_q && (wstrb_q != '1) && (partial_q != '1))
        partial_q <= partial_q + 32'd1;
    end
  end

  assign words_o   = words_q;
  assign partial_o = partial_q;
`endif

endmodule

// File: tb/tb_sfm_int_packer.sv
// Randomized bench for sfm_int_packer against a queue-based model of slots and pending words.
module tb_sfm_int_packer;
  localparam int DW = 256;
  localparam int H  = 128;

  logic          clk = 1'b0;
  logic          rst_n, clear, enable, flush;
  logic          busy;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [31:0]   in_strb, out_strb;
`ifdef SFM_INT_PACKER_STATS_EN
  logic [31:0]   words, partial;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: accepted beats of the open word, and completed words awaiting drain.
  logic [H-1:0]  part_d[$];
  logic [15:0]   part_s[$];
  logic [DW-1:0] pend_d[$];
  logic [31:0]   pend_s[$];
  bit            pend_f[$];
  int            m_words   = 0;
  int            m_partial = 0;

  always #5 clk = ~clk;

  sfm_int_packer dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .flush_i(flush),
    .busy_o(busy),
    .stream_i_valid(in_valid), .stream_i_ready(in_ready),
    .stream_i_data(in_data), .stream_i_strb(in_strb),
    .stream_o_valid(out_valid), .stream_o_ready(out_ready),
    .stream_o_data(out_data), .stream_o_strb(out_strb)
`ifdef SFM_INT_PACKER_STATS_EN
    , .words_o(words), .partial_o(partial)
`endif
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [H-1:0] b);
    logic [DW-1:0] w;
    w = {DW/H{b}};
    return w;
  endfunction

  task automatic model_clear();
    part_d.delete(); part_s.delete();
    pend_d.delete(); pend_s.delete(); pend_f.delete();
    m_words = 0; m_partial = 0;
  endtask

  task automatic close_word(input bit via_flush);
    logic [DW-1:0] w;
    logic [31:0]   s;
    w = '0; s = '0;
    foreach (part_d[i]) begin
      w[i*H +: H]   = part_d[i];
      s[i*16 +: 16] = part_s[i];
    end
    pend_d.push_back(w); pend_s.push_back(s); pend_f.push_back(via_flush);
    part_d.delete(); part_s.delete();
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, return at next negedge.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [31:0] s,
                      input bit ordy, input bit fl, input bit en, input bit clr);
    bit exp_v, exp_ir, ofire, ifire;
    in_valid = v; in_data = d; in_strb = s; out_ready = ordy;
    flush = fl; enable = en; clear = clr;
    #1;
    if (en) begin
      exp_v  = (pend_d.size() != 0);
      exp_ir = !exp_v || ordy;
      check_eq("out_valid", DW'(out_valid), DW'(exp_v));
      if (exp_v) begin
        check_eq("out_data", out_data, pend_d[0]);
        check_eq("out_strb", DW'(out_strb), DW'(pend_s[0]));
      end
    end else begin
      exp_v  = v;
      exp_ir = ordy;
      check_eq("pt_valid", DW'(out_valid), DW'(v));
      check_eq("pt_data", out_data, d);
      check_eq("pt_strb", DW'(out_strb), DW'(s));
    end
    check_eq("in_ready", DW'(in_ready), DW'(exp_ir));
    check_eq("busy", DW'(busy), DW'((pend_d.size() != 0) || (part_d.size() != 0)));
    if (clr) begin
      model_clear();
    end else if (en) begin
      ofire = exp_v && ordy;
      ifire = v && exp_ir;
      if (ofire) begin
        m_words++;
        if (pend_f[0] && pend_s[0] != 32'hFFFF_FFFF) m_partial++;
        void'(pend_d.pop_front()); void'(pend_s.pop_front()); void'(pend_f.pop_front());
      end
      if (ifire) begin
        part_d.push_back(d[H-1:0]); part_s.push_back(s[15:0]);
        if (part_d.size() == 2) close_word(1'b0);
      end
      if (fl && part_d.size() != 0 && pend_d.size() == 0) close_word(1'b1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, rand_word(), $urandom, ordy, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", DW'(out_valid), '0);
    check_eq("rst_busy", DW'(busy), '0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [H-1:0] a, b;
    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_strb = '0; out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // Two beats pack into one dense word.
    a = {16{8'h11}}; b = {16{8'h22}};
    step(1'b1, fill(a), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, fill(b), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("pair_word", out_data, {b, a});
    idle(2, 1'b1);

    // Back-to-back beats with random padding.
    for (int i = 0; i < 6; i++) step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Flush a lone beat, then flush while empty.
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, rand_word(), '1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("flush_strb", DW'(out_strb), DW'(32'h0000_FFFF));
    idle(1, 1'b1);
    step(1'b0, rand_word(), '1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Stall a full word for five cycles, then release with a beat waiting.
    step(1'b1, rand_word(), '1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), '1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Mid-word reset, then mid-word clear; both restart from slot 0.
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Random packing traffic with backpressure, partial strobes and flushes.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, rand_word(),
           ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'b1, 1'b0);
    step(1'b0, rand_word(), '1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

`ifdef SFM_INT_PACKER_STATS_EN
    check_eq("words_cnt", DW'(words), DW'(m_words));
    check_eq("partial_cnt", DW'(partial), DW'(m_partial));
`endif

    // Pass-through with random traffic; packing state must survive untouched.
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) != 0, rand_word(), $urandom,
           $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_word(), '1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

`ifdef SFM_INT_PACKER_STATS_EN
    check_eq("words_end", DW'(words), DW'(m_words));
    check_eq("partial_end", DW'(partial), DW'(m_partial));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
